window_buffer_ctrl: RTL and testbench
=====================================

WINDOW_BUFFER_CTRL -- requirements
Module: window_buffer_ctrl

Interface
REQ-001 The block SHALL have parameter INTEGER_BITS, default 8, integer bits per pixel.
REQ-002 The block SHALL have parameter FIXED_POINT_BITS, default 4, fraction bits per pixel; DW = INTEGER_BITS+FIXED_POINT_BITS.
REQ-003 The block SHALL have parameter IMG_WIDTH, default 512, pixels per line (>= KERNEL).
REQ-004 The block SHALL have parameter IMG_HEIGHT, default 512, lines per frame (>= KERNEL).
REQ-005 The block SHALL have parameter KERNEL, default 3, window edge (odd, 3..7); line buffers NL = KERNEL+1.
REQ-006 The block SHALL have port i_clk, input, 1 bit: the only clock, rising edge.
REQ-007 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port i_pixel_data, input, DW bits: raster-order pixel.
REQ-009 The block SHALL have port i_pixel_data_valid, input, 1 bit: pixel offered.
REQ-010 The block SHALL have port o_pixel_ready, output, 1 bit: pixel accepted when valid & ready.
REQ-011 The block SHALL have port o_window_data, output, DW*KERNEL*KERNEL bits: window, row r (0 = oldest line), column c at bits [(r*KERNEL+c)*DW +: DW].
REQ-012 The block SHALL have port o_window_valid, output, 1 bit: window presented.
REQ-013 The block SHALL have port i_window_ready, input, 1 bit: consumer accepts when valid & ready.
REQ-014 The block SHALL have port o_intr, output, 1 bit: one-cycle pulse per completed output line.
REQ-015 The block SHALL have port o_frame_done, output, 1 bit: one-cycle pulse after the last output line of a frame.

Function
REQ-016 Write: an accepted pixel SHALL be stored at column wr_col of buffer wr_buf; wr_col wraps IMG_WIDTH-1 -> 0 and then wr_buf advances modulo NL.
REQ-017 Fill counter stored SHALL be incremented by 1 per accepted pixel and decremented by IMG_WIDTH per released line; both in the same cycle SHALL apply +1-IMG_WIDTH.
REQ-018 o_pixel_ready SHALL be low exactly when stored == NL*IMG_WIDTH; never overwrite unreleased data.
REQ-019 Read FSM states SHALL be IDLE, RD_LINE, LINE_DONE.
REQ-020 IDLE -> RD_LINE when stored >= KERNEL*IMG_WIDTH; rd_col cleared to 0.
REQ-021 In RD_LINE, each window handshake SHALL advance rd_col by 1; window at rd_col SHALL hold columns rd_col..rd_col+KERNEL-1 of the KERNEL buffers starting at rd_buf.
REQ-022 RD_LINE SHALL emit exactly IMG_WIDTH-KERNEL+1 windows per line (valid-region convolution, no padding).
REQ-023 Handshake on the last window SHALL go to LINE_DONE; LINE_DONE SHALL release buffer rd_buf, advance rd_buf modulo NL, pulse o_intr, and return to IDLE next cycle.
REQ-024 Output line counter SHALL count to IMG_HEIGHT-KERNEL+1; o_frame_done SHALL pulse together with o_intr of the last line; on that line the remaining KERNEL-1 lines SHALL also be released (stored decremented by KERNEL*IMG_WIDTH) so the next frame starts clean; counters return to 0.
REQ-025 o_window_data/o_window_valid SHALL be registered: first window valid 2 cycles after the IDLE->RD_LINE condition holds (1 cycle RAM read, 1 cycle output register).
REQ-026 While o_window_valid & !i_window_ready, o_window_data SHALL hold stable and no read address SHALL advance.
REQ-027 o_window_valid SHALL never be high in IDLE or LINE_DONE.

Reset
REQ-028 Asserting i_rst_n low SHALL at once clear stored, wr_col, wr_buf, rd_col, rd_buf, line counter, FSM to IDLE, o_window_valid=0, o_intr=0, o_frame_done=0, o_pixel_ready=1 after release; o_window_data=0.
REQ-029 Reset mid-frame SHALL discard all buffered pixels; buffer RAM contents need not be cleared.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding and the DW / NL / window-width derived constants.
REQ-031 One sub-module window_line_ram (single line, 1 write port, KERNEL-wide registered read) SHALL be instantiated NL times.

Verification (IMG_WIDTH=8, IMG_HEIGHT=5, KERNEL=3)
REQ-032 Stream 40 pixels of value n (pixel index), consumer always ready -> 18 windows, first window rows {0,1,2},{8,9,10},{16,17,18}; 3 o_intr pulses; 1 o_frame_done.
REQ-033 Producer always valid, consumer ready low -> o_pixel_ready drops after exactly 32 accepted pixels; window 0 held stable.
REQ-034 i_window_ready toggling 1/0 each cycle -> same 18 windows in same order, none duplicated or dropped.
REQ-035 Two back-to-back frames (80 pixels) -> 36 windows, 2 o_frame_done, frame-2 first window starts with pixel 40.
REQ-036 Assert i_rst_n low after 20 pixels, then resend 40 -> output identical to REQ-032; no stale pixel observed.

Source files
------------

// File: rtl/window_buffer_ctrl_pkg.sv
// Shared types and derived-width helpers for the sliding-window line buffer controller.
package window_buffer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_LINE   = 2'd1,
    LINE_DONE = 2'd2
  } rd_state_t;

  localparam int DEF_INTEGER_BITS     = 8;
  localparam int DEF_FIXED_POINT_BITS = 4;
  localparam int DEF_KERNEL           = 3;

  function automatic int calc_dw(input int integer_bits, input int fixed_point_bits);
    return integer_bits + fixed_point_bits;
  endfunction

  // One line buffer more than the kernel height lets writing overlap reading.
  function automatic int calc_nl(input int kernel);
    return kernel + 1;
  endfunction

  function automatic int calc_win_w(input int dw, input int kernel);
    return dw * kernel * kernel;
  endfunction

  localparam int DEF_DW    = calc_dw(DEF_INTEGER_BITS, DEF_FIXED_POINT_BITS);
  localparam int DEF_NL    = calc_nl(DEF_KERNEL);
  localparam int DEF_WIN_W = calc_win_w(DEF_DW, DEF_KERNEL);

endpackage

// File: rtl/window_line_ram.sv
// One image line of storage: single write port, registered read of KERNEL adjacent pixels.
module window_line_ram #(
  parameter int DW     = 12,
  parameter int WIDTH  = 512,
  parameter int KERNEL = 3,
  parameter int AW     = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic                 re,
  input  logic [AW-1:0]        rd_addr,
  output logic [KERNEL*DW-1:0] rd_data
);

  logic [DW-1:0] mem [WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // rd_data holds its value when re is low so a stalled consumer sees stable data.
  always_ff @(posedge clk) begin
    if (re) begin
      for (int k = 0; k < KERNEL; k++) rd_data[k*DW +: DW] <= mem[rd_addr + AW'(k)];
    end
  end

endmodule

// File: rtl/window_buffer_ctrl.sv
// Streams raster pixels into NL line buffers and emits KERNEL x KERNEL valid-region windows.
module window_buffer_ctrl
  import window_buffer_ctrl_pkg::*;
#(
  parameter int INTEGER_BITS     = 8,
  parameter int FIXED_POINT_BITS = 4,
  parameter int IMG_WIDTH        = 512,
  parameter int IMG_HEIGHT       = 512,
  parameter int KERNEL           = 3
) (
  input  logic                                                     i_clk,
  input  logic                                                     i_rst_n,
  input  logic [INTEGER_BITS+FIXED_POINT_BITS-1:0]                 i_pixel_data,
  input  logic                                                     i_pixel_data_valid,
  output logic                                                     o_pixel_ready,
  output logic [(INTEGER_BITS+FIXED_POINT_BITS)*KERNEL*KERNEL-1:0] o_window_data,
  output logic                                                     o_window_valid,
  input  logic                                                     i_window_ready,
  output logic                                                     o_intr,
  output logic                                                     o_frame_done
);

  localparam int DW    = calc_dw(INTEGER_BITS, FIXED_POINT_BITS);
  localparam int NL    = calc_nl(KERNEL);
  localparam int ROW_W = DW * KERNEL;
  localparam int WIN_W = calc_win_w(DW, KERNEL);
  localparam int AW    = $clog2(IMG_WIDTH);
  localparam int BW    = $clog2(NL);
  localparam int SW    = $clog2(NL * IMG_WIDTH + 1);
  localparam int LW    = $clog2(IMG_HEIGHT);

  localparam logic [AW-1:0] LAST_COL    = AW'(IMG_WIDTH - KERNEL);
  localparam logic [AW-1:0] LAST_WR_COL = AW'(IMG_WIDTH - 1);
  localparam logic [LW-1:0] LAST_LINE   = LW'(IMG_HEIGHT - KERNEL);
  localparam logic [SW-1:0] FULL        = SW'(NL * IMG_WIDTH);
  localparam logic [SW-1:0] START_LEVEL = SW'(KERNEL * IMG_WIDTH);
  localparam logic [SW-1:0] LINE_WORDS  = SW'(IMG_WIDTH);

  rd_state_t        state, state_next;
  logic [SW-1:0]    stored, release_amt;
  logic [AW-1:0]    wr_col, rd_col, iss_col, rd_addr;
  logic [BW-1:0]    wr_buf, rd_buf;
  logic [LW-1:0]    line_cnt;
  logic             accept, advance, handshake, issue, last_line, s1_valid;
  logic [NL-1:0]    we;
  logic [ROW_W-1:0] ram_q [NL];
  logic [WIN_W-1:0] win_mux;

  assign o_pixel_ready = (stored != FULL);
  assign accept        = i_pixel_data_valid && o_pixel_ready;
  assign advance       = !o_window_valid || i_window_ready;
  assign handshake     = o_window_valid && i_window_ready;
  assign last_line     = (line_cnt == LAST_LINE);
  assign o_intr        = (state == LINE_DONE);
  assign o_frame_done  = o_intr && last_line;
  // The last line of a frame also frees the KERNEL-1 lines that only it still needed.
  assign release_amt   = (state != LINE_DONE) ? '0 : (last_line ? START_LEVEL : LINE_WORDS);

  for (genvar b = 0; b < NL; b++) begin : g_line
    assign we[b] = accept && (wr_buf == BW'(b));
    window_line_ram #(.DW(DW), .WIDTH(IMG_WIDTH), .KERNEL(KERNEL)) u_ram (
      .clk     (i_clk),
      .we      (we[b]),
      .wr_addr (wr_col),
      .wr_data (i_pixel_data),
      .re      (issue),
      .rd_addr (rd_addr),
      .rd_data (ram_q[b])
    );
  end

  always_comb begin
    win_mux = '0;
    for (int r = 0; r < KERNEL; r++)
      win_mux[r*ROW_W +: ROW_W] = ram_q[BW'((int'(rd_buf) + r) % NL)];
  end

  // Reads are issued ahead of handshakes (iss_col) so a ready consumer gets one window per cycle.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    rd_addr    = iss_col;
    unique case (state)
      IDLE: begin
        if (stored >= START_LEVEL) begin
          state_next = RD_LINE;
          issue      = 1'b1;
          rd_addr    = '0;
        end
      end
      RD_LINE: begin
        issue = advance && (iss_col <= LAST_COL);
        if (handshake && (rd_col == LAST_COL)) state_next = LINE_DONE;
      end
      LINE_DONE: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stored <= '0;
      wr_col <= '0;
      wr_buf <= '0;
    end else begin
      stored <= stored + SW'(accept) - release_amt;
      if (accept) begin
        if (wr_col == LAST_WR_COL) begin
          wr_col <= '0;
          wr_buf <= BW'((int'(wr_buf) + 1) % NL);
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      rd_col   <= '0;
      iss_col  <= '0;
      rd_buf   <= '0;
      line_cnt <= '0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && issue) begin
        rd_col  <= '0;
        iss_col <= AW'(1);
      end else begin
        if (issue)     iss_col <= iss_col + 1'b1;
        if (handshake) rd_col  <= rd_col + 1'b1;
      end
      if (state == LINE_DONE) begin
        rd_buf   <= BW'((int'(rd_buf) + (last_line ? KERNEL : 1)) % NL);
        line_cnt <= last_line ? '0 : line_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid       <= 1'b0;
      o_window_valid <= 1'b0;
      o_window_data  <= '0;
    end else if (advance) begin
      s1_valid       <= issue;
      o_window_valid <= s1_valid;
      if (s1_valid) o_window_data <= win_mux;
    end
  end

endmodule

// File: tb/tb_window_buffer_ctrl.sv
// Directed and randomized checks of window_buffer_ctrl against a frame-level window model.
module tb_window_buffer_ctrl;

  localparam int IB    = 8;
  localparam int FB    = 4;
  localparam int DW    = IB + FB;
  localparam int W     = 8;
  localparam int H     = 5;
  localparam int K     = 3;
  localparam int NL    = K + 1;
  localparam int WIN_W = DW * K * K;
  localparam int WPL   = W - K + 1;
  localparam int WPF   = WPL * (H - K + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DW-1:0]    pix_data;
  logic             pix_valid;
  logic             pix_ready;
  logic [WIN_W-1:0] win_data;
  logic             win_valid;
  logic             win_ready;
  logic             intr;
  logic             frame_done;

  int n_assert = 0;
  int n_fail   = 0;
  int intr_cnt, fd_cnt, cyc, t24, tfv;
  int valid_pct  = 100;
  int ready_mode = 0;

  logic [DW-1:0]    tx_q[$];
  logic [DW-1:0]    acc_q[$];
  logic [WIN_W-1:0] obs_q[$];

  always #5 clk = ~clk;

  window_buffer_ctrl #(
    .INTEGER_BITS(IB), .FIXED_POINT_BITS(FB), .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL(K)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_pixel_data       (pix_data),
    .i_pixel_data_valid (pix_valid),
    .o_pixel_ready      (pix_ready),
    .o_window_data      (win_data),
    .o_window_valid     (win_valid),
    .i_window_ready     (win_ready),
    .o_intr             (intr),
    .o_frame_done       (frame_done)
  );

  // Drive after the rising edge; producer and consumer behaviour set by valid_pct/ready_mode.
  always @(posedge clk) begin
    #1;
    pix_valid = (tx_q.size() > 0) && ($urandom_range(99) < valid_pct);
    pix_data  = (tx_q.size() > 0) ? tx_q[0] : '0;
    case (ready_mode)
      0:       win_ready = 1'b1;
      1:       win_ready = 1'b0;
      2:       win_ready = ~win_ready;
      default: win_ready = 1'($urandom_range(1));
    endcase
  end

  // Record handshakes and pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (pix_valid && pix_ready) begin
        acc_q.push_back(pix_data);
        if (tx_q.size() > 0) void'(tx_q.pop_front());
        if (acc_q.size() == 24 && t24 < 0) t24 = cyc;
      end
      if (win_valid && tfv < 0) tfv = cyc;
      if (win_valid && win_ready) obs_q.push_back(win_data);
      if (intr) intr_cnt++;
      if (frame_done) fd_cnt++;
    end
  end

  task automatic check_output(input string tag, input logic [WIN_W-1:0] observed,
                              input logic [WIN_W-1:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_logs();
    acc_q.delete();
    obs_q.delete();
    intr_cnt = 0;
    fd_cnt   = 0;
    t24      = -1;
    tfv      = -1;
  endtask

  task automatic apply_stimulus(input int start, input int count, input bit random_values);
    for (int i = 0; i < count; i++)
      tx_q.push_back(random_values ? DW'($urandom_range(4095)) : DW'(start + i));
  endtask

  task automatic wait_windows(input string tag, input int n, input int budget);
    int c = 0;
    while ((obs_q.size() < n || tx_q.size() > 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_output({tag, "_timeout"}, WIN_W'(c < budget), WIN_W'(1));
    repeat (12) @(negedge clk);
  endtask

  // Window model: element (r,c) of output (y,x) is accepted pixel (y+r)*W + x+c of its frame.
  function automatic logic [WIN_W-1:0] model_window(input int f, input int y, input int x);
    logic [WIN_W-1:0] w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        int idx = f * W * H + (y + r) * W + x + c;
        w[(r*K + c)*DW +: DW] = (idx < acc_q.size()) ? acc_q[idx] : 'x;
      end
    return w;
  endfunction

  function automatic logic [WIN_W-1:0] ramp_window(input int base);
    logic [WIN_W-1:0] w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) w[(r*K + c)*DW +: DW] = DW'(base + r * W + c);
    return w;
  endfunction

  task automatic compare_windows(input string tag, input int frames);
    check_output({tag, "_pixels"}, WIN_W'(acc_q.size()), WIN_W'(frames * W * H));
    check_output({tag, "_count"}, WIN_W'(obs_q.size()), WIN_W'(frames * WPF));
    for (int f = 0; f < frames; f++)
      for (int y = 0; y <= H - K; y++)
        for (int x = 0; x < WPL; x++) begin
          int i = f * WPF + y * WPL + x;
          if (i < obs_q.size())
            check_output($sformatf("%s_win%0d", tag, i), obs_q[i], model_window(f, y, x));
        end
  endtask

  initial begin
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = '0;
    win_ready = 1'b1;
    cyc       = 0;
    clear_logs();
    #23;
    check_output("reset_win_valid", WIN_W'(win_valid), WIN_W'(0));
    check_output("reset_win_data", win_data, '0);
    check_output("reset_intr", WIN_W'(intr), WIN_W'(0));
    check_output("reset_frame_done", WIN_W'(frame_done), WIN_W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("reset_pix_ready", WIN_W'(pix_ready), WIN_W'(1));

    $display("[TB] ramp frame, consumer always ready");
    apply_stimulus(0, 40, 1'b0);
    wait_windows("a", WPF, 400);
    compare_windows("a", 1);
    check_output("a_first", (obs_q.size() > 0) ? obs_q[0] : 'x, ramp_window(0));
    check_output("a_intr", WIN_W'(intr_cnt), WIN_W'(3));
    check_output("a_frame_done", WIN_W'(fd_cnt), WIN_W'(1));
    check_output("a_latency", WIN_W'(tfv - t24), WIN_W'(3));

    $display("[TB] consumer stalled, buffer fills");
    clear_logs();
    ready_mode = 1;
    apply_stimulus(0, 40, 1'b0);
    repeat (60) @(negedge clk);
    #1;
    check_output("b_accepted", WIN_W'(acc_q.size()), WIN_W'(NL * W));
    check_output("b_pix_ready", WIN_W'(pix_ready), WIN_W'(0));
    check_output("b_win_valid", WIN_W'(win_valid), WIN_W'(1));
    check_output("b_win0", win_data, ramp_window(0));
    repeat (10) @(negedge clk);
    #1;
    check_output("b_win0_hold", win_data, model_window(0, 0, 0));
    ready_mode = 0;
    wait_windows("b", WPF, 400);
    compare_windows("b", 1);
    check_output("b_frame_done", WIN_W'(fd_cnt), WIN_W'(1));

    $display("[TB] consumer ready toggling");
    clear_logs();
    ready_mode = 2;
    apply_stimulus(0, 40, 1'b0);
    wait_windows("c", WPF, 600);
    compare_windows("c", 1);
    check_output("c_intr", WIN_W'(intr_cnt), WIN_W'(3));

    $display("[TB] two back-to-back frames");
    clear_logs();
    ready_mode = 0;
    apply_stimulus(0, 80, 1'b0);
    wait_windows("d", 2 * WPF, 800);
    compare_windows("d", 2);
    check_output("d_frame_done", WIN_W'(fd_cnt), WIN_W'(2));
    check_output("d_intr", WIN_W'(intr_cnt), WIN_W'(6));
    check_output("d_f2_first", (obs_q.size() > WPF) ? obs_q[WPF] : 'x, ramp_window(40));

    $display("[TB] reset mid-frame then resend");
    clear_logs();
    apply_stimulus(100, 20, 1'b0);
    wait_windows("e_pre", 0, 200);
    check_output("e_pre_accepted", WIN_W'(acc_q.size()), WIN_W'(20));
    rst_n = 1'b0;
    #1;
    tx_q.delete();
    clear_logs();
    check_output("e_reset_win_valid", WIN_W'(win_valid), WIN_W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(0, 40, 1'b0);
    wait_windows("e", WPF, 400);
    compare_windows("e", 1);
    check_output("e_first", (obs_q.size() > 0) ? obs_q[0] : 'x, ramp_window(0));
    check_output("e_frame_done", WIN_W'(fd_cnt), WIN_W'(1));

    $display("[TB] random pixels, random valid and ready");
    clear_logs();
    valid_pct  = 60;
    ready_mode = 3;
    apply_stimulus(0, 80, 1'b1);
    wait_windows("f", 2 * WPF, 3000);
    compare_windows("f", 2);
    check_output("f_frame_done", WIN_W'(fd_cnt), WIN_W'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
